// File: rtl/exec_operand_stage_if.sv
// Bundle of issue, ALU, LSU-response and writeback signals around the operand stage.
// The master side is the issuing/ALU/LSU environment; the slave side is the stage.
interface exec_operand_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5
);
  logic                     issue_valid_i;
  logic                     issue_ready_o;
  logic [1:0]               op_a_sel_i;
  logic [1:0]               op_b_sel_i;
  logic                     rs1_valid_i;
  logic                     rs2_valid_i;
  logic                     imm_valid_i;
  logic [RF_ADDR_WIDTH-1:0] rs1_addr_i;
  logic [RF_ADDR_WIDTH-1:0] rs2_addr_i;
  logic [DATA_WIDTH-1:0]    rs1_data_i;
  logic [DATA_WIDTH-1:0]    rs2_data_i;
  logic [DATA_WIDTH-1:0]    imm_i;
  logic [DATA_WIDTH-1:0]    pc_i;
  logic [RF_ADDR_WIDTH-1:0] rd_addr_i;
  logic                     rd_we_i;
  logic [1:0]               wb_sel_i;
  logic                     alu_valid_o;
  logic [DATA_WIDTH-1:0]    alu_op_a_o;
  logic [DATA_WIDTH-1:0]    alu_op_b_o;
  logic [DATA_WIDTH-1:0]    alu_result_i;
  logic                     mem_rvalid_i;
  logic [DATA_WIDTH-1:0]    mem_rdata_i;
  logic                     rf_we_o;
  logic [RF_ADDR_WIDTH-1:0] rf_waddr_o;
  logic [DATA_WIDTH-1:0]    rf_wdata_o;

  modport master (
    output issue_valid_i, op_a_sel_i, op_b_sel_i, rs1_valid_i, rs2_valid_i, imm_valid_i,
           rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i, imm_i, pc_i,
           rd_addr_i, rd_we_i, wb_sel_i, alu_result_i, mem_rvalid_i, mem_rdata_i,
    input  issue_ready_o, alu_valid_o, alu_op_a_o, alu_op_b_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );

  modport slave (
    input  issue_valid_i, op_a_sel_i, op_b_sel_i, rs1_valid_i, rs2_valid_i, imm_valid_i,
           rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i, imm_i, pc_i,
           rd_addr_i, rd_we_i, wb_sel_i, alu_result_i, mem_rvalid_i, mem_rdata_i,
    output issue_ready_o, alu_valid_o, alu_op_a_o, alu_op_b_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );
endinterface

// File: rtl/exec_operand_stage.sv
// Execute-stage operand selection with EX/WB forwarding, ALU handoff and a
// single-entry writeback register that also waits for LSU responses.
module exec_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int FWD_EN        = 1
) (
  input logic                clk_i,
  input logic                rst_i,
  exec_operand_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_MEM} state_t;

  localparam logic [1:0] WB_PC4 = 2'd1;
  localparam logic [1:0] WB_LSU = 2'd2;

  state_t                   state;
  state_t                   state_next;
  logic [RF_ADDR_WIDTH-1:0] ex_rd;
  logic                     ex_we;
  logic [1:0]               ex_wb_sel;
  logic [DATA_WIDTH-1:0]    ex_pc;
  logic [DATA_WIDTH-1:0]    pc_plus4;
  logic                     handshake;
  logic                     ex_fwd_ok;
  logic [DATA_WIDTH-1:0]    ex_fwd_data;
  logic [DATA_WIDTH-1:0]    rs1_val;
  logic [DATA_WIDTH-1:0]    rs2_val;
  logic [DATA_WIDTH-1:0]    op_a;
  logic [DATA_WIDTH-1:0]    op_b;
  logic                     wb_fire;
  logic [DATA_WIDTH-1:0]    wb_data;

  assign pc_plus4          = ex_pc + DATA_WIDTH'(4);
  assign bus.alu_valid_o   = (state == EXEC);
  assign bus.issue_ready_o = (state == IDLE) || ((state == EXEC) && (ex_wb_sel != WB_LSU));
  assign handshake         = bus.issue_valid_i && bus.issue_ready_o;

  // An LSU instruction in EX has no result yet, so it never feeds the EX bypass.
  assign ex_fwd_ok   = (FWD_EN != 0) && bus.alu_valid_o && ex_we && (ex_wb_sel != WB_LSU);
  assign ex_fwd_data = (ex_wb_sel == WB_PC4) ? pc_plus4 : bus.alu_result_i;

  function automatic logic [DATA_WIDTH-1:0] resolve_src(
    input logic                     src_valid,
    input logic [RF_ADDR_WIDTH-1:0] src_addr,
    input logic [DATA_WIDTH-1:0]    src_data
  );
    logic [DATA_WIDTH-1:0] val;
    val = src_data;
    if (!src_valid) begin
      val = '0;
    end else if (src_addr != '0) begin
      if (ex_fwd_ok && (ex_rd == src_addr)) begin
        val = ex_fwd_data;
      end else if ((FWD_EN != 0) && bus.rf_we_o && (bus.rf_waddr_o == src_addr)) begin
        val = bus.rf_wdata_o;
      end
    end
    return val;
  endfunction

  always_comb begin
    rs1_val = resolve_src(bus.rs1_valid_i, bus.rs1_addr_i, bus.rs1_data_i);
    rs2_val = resolve_src(bus.rs2_valid_i, bus.rs2_addr_i, bus.rs2_data_i);
    op_a    = '0;
    op_b    = '0;
    case (bus.op_a_sel_i)
      2'd0:    op_a = rs1_val;
      2'd1:    op_a = bus.pc_i;
      2'd2:    op_a = bus.imm_valid_i ? bus.imm_i : '0;
      default: op_a = '0;
    endcase
    case (bus.op_b_sel_i)
      2'd0:    op_b = rs2_val;
      2'd1:    op_b = bus.imm_valid_i ? bus.imm_i : '0;
      default: op_b = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    wb_fire    = 1'b0;
    wb_data    = bus.alu_result_i;
    case (state)
      IDLE: begin
        if (handshake) state_next = EXEC;
      end
      EXEC: begin
        if (ex_wb_sel == WB_LSU) begin
          state_next = WAIT_MEM;
        end else begin
          wb_fire    = ex_we;
          wb_data    = ex_fwd_data;
          state_next = handshake ? EXEC : IDLE;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid_i) begin
          wb_fire    = ex_we;
          wb_data    = bus.mem_rdata_i;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Writeback address/data only move on a real write so they hold otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      ex_rd          <= '0;
      ex_we          <= 1'b0;
      ex_wb_sel      <= '0;
      ex_pc          <= '0;
      bus.alu_op_a_o <= '0;
      bus.alu_op_b_o <= '0;
      bus.rf_we_o    <= 1'b0;
      bus.rf_waddr_o <= '0;
      bus.rf_wdata_o <= '0;
    end else begin
      state       <= state_next;
      bus.rf_we_o <= wb_fire;
      if (handshake) begin
        ex_rd          <= bus.rd_addr_i;
        ex_we          <= bus.rd_we_i;
        ex_wb_sel      <= bus.wb_sel_i;
        ex_pc          <= bus.pc_i;
        bus.alu_op_a_o <= op_a;
        bus.alu_op_b_o <= op_b;
      end
      if (wb_fire) begin
        bus.rf_waddr_o <= ex_rd;
        bus.rf_wdata_o <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_exec_operand_stage.sv
// Directed bench: one stage with forwarding, one without, driven with identical
// instruction streams; the bench plays the role of an adder ALU.
module tb_exec_operand_stage;

  logic clk;
  logic rst;
  int   assert_count;
  int   fail_count;

  exec_operand_stage_if #(.DATA_WIDTH(32), .RF_ADDR_WIDTH(5)) bus_fwd ();
  exec_operand_stage_if #(.DATA_WIDTH(32), .RF_ADDR_WIDTH(5)) bus_nofwd ();

  exec_operand_stage #(.DATA_WIDTH(32), .RF_ADDR_WIDTH(5), .FWD_EN(1)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus_fwd)
  );

  exec_operand_stage #(.DATA_WIDTH(32), .RF_ADDR_WIDTH(5), .FWD_EN(0)) dut_nofwd (
    .clk_i(clk), .rst_i(rst), .bus(bus_nofwd)
  );

  assign bus_fwd.alu_result_i   = bus_fwd.alu_op_a_o + bus_fwd.alu_op_b_o;
  assign bus_nofwd.alu_result_i = bus_nofwd.alu_op_a_o + bus_nofwd.alu_op_b_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drives the same issue slot into both stages.
  task automatic applyStimulus(
    input logic        valid,
    input logic [1:0]  a_sel,
    input logic [1:0]  b_sel,
    input logic [4:0]  rs1,
    input logic [31:0] rs1_data,
    input logic [4:0]  rs2,
    input logic [31:0] rs2_data,
    input logic [31:0] imm,
    input logic [31:0] pc,
    input logic [4:0]  rd,
    input logic        we,
    input logic [1:0]  wb
  );
    bus_fwd.issue_valid_i = valid;  bus_nofwd.issue_valid_i = valid;
    bus_fwd.op_a_sel_i    = a_sel;  bus_nofwd.op_a_sel_i    = a_sel;
    bus_fwd.op_b_sel_i    = b_sel;  bus_nofwd.op_b_sel_i    = b_sel;
    bus_fwd.rs1_valid_i   = 1'b1;   bus_nofwd.rs1_valid_i   = 1'b1;
    bus_fwd.rs2_valid_i   = 1'b1;   bus_nofwd.rs2_valid_i   = 1'b1;
    bus_fwd.imm_valid_i   = 1'b1;   bus_nofwd.imm_valid_i   = 1'b1;
    bus_fwd.rs1_addr_i    = rs1;    bus_nofwd.rs1_addr_i    = rs1;
    bus_fwd.rs1_data_i    = rs1_data; bus_nofwd.rs1_data_i  = rs1_data;
    bus_fwd.rs2_addr_i    = rs2;    bus_nofwd.rs2_addr_i    = rs2;
    bus_fwd.rs2_data_i    = rs2_data; bus_nofwd.rs2_data_i  = rs2_data;
    bus_fwd.imm_i         = imm;    bus_nofwd.imm_i         = imm;
    bus_fwd.pc_i          = pc;     bus_nofwd.pc_i          = pc;
    bus_fwd.rd_addr_i     = rd;     bus_nofwd.rd_addr_i     = rd;
    bus_fwd.rd_we_i       = we;     bus_nofwd.rd_we_i       = we;
    bus_fwd.wb_sel_i      = wb;     bus_nofwd.wb_sel_i      = wb;
  endtask

  task automatic setMem(input logic rvalid, input logic [31:0] rdata);
    bus_fwd.mem_rvalid_i = rvalid; bus_nofwd.mem_rvalid_i = rvalid;
    bus_fwd.mem_rdata_i  = rdata;  bus_nofwd.mem_rdata_i  = rdata;
  endtask

  task automatic idleIssue();
    bus_fwd.issue_valid_i   = 1'b0;
    bus_nofwd.issue_valid_i = 1'b0;
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    rst          = 1'b1;
    applyStimulus(1'b0, 2'd3, 2'd2, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0);
    setMem(1'b0, 32'h0);
    step();
    step();
    rst = 1'b0;

    checkOutput("reset_ready", {31'b0, bus_fwd.issue_ready_o}, 32'd1);
    checkOutput("reset_alu_valid", {31'b0, bus_fwd.alu_valid_o}, 32'd0);
    checkOutput("reset_rf_we", {31'b0, bus_fwd.rf_we_o}, 32'd0);
    checkOutput("reset_op_a", bus_fwd.alu_op_a_o, 32'h0);
    checkOutput("reset_wdata", bus_fwd.rf_wdata_o, 32'h0);

    // ADDI x1 = 0 + 5, then ADD x2 = x1 + x1 back to back
    applyStimulus(1'b1, 2'd3, 2'd1, 5'd0, 32'h0, 5'd0, 32'h0, 32'd5, 32'h100, 5'd1, 1'b1, 2'd0);
    step();
    checkOutput("addi_alu_valid", {31'b0, bus_fwd.alu_valid_o}, 32'd1);
    checkOutput("addi_op_b", bus_fwd.alu_op_b_o, 32'd5);
    checkOutput("addi_ready_exec", {31'b0, bus_fwd.issue_ready_o}, 32'd1);
    applyStimulus(1'b1, 2'd0, 2'd0, 5'd1, 32'h111, 5'd1, 32'h111, 32'h0, 32'h104, 5'd2, 1'b1, 2'd0);
    step();
    checkOutput("add_fwd_op_a", bus_fwd.alu_op_a_o, 32'd5);
    checkOutput("add_fwd_op_b", bus_fwd.alu_op_b_o, 32'd5);
    checkOutput("addi_wb_we", {31'b0, bus_fwd.rf_we_o}, 32'd1);
    checkOutput("addi_wb_data", bus_fwd.rf_wdata_o, 32'd5);
    checkOutput("nofwd_op_a", bus_nofwd.alu_op_a_o, 32'h111);
    idleIssue();
    step();
    checkOutput("add_wb_data", bus_fwd.rf_wdata_o, 32'd10);
    checkOutput("add_wb_addr", {27'b0, bus_fwd.rf_waddr_o}, 32'd2);
    checkOutput("nofwd_add_wb", bus_nofwd.rf_wdata_o, 32'h222);
    step();
    checkOutput("wb_pulse_end", {31'b0, bus_fwd.rf_we_o}, 32'd0);
    checkOutput("wb_data_hold", bus_fwd.rf_wdata_o, 32'd10);

    // LW x3, response three cycles after the handshake, then a dependent op
    applyStimulus(1'b1, 2'd0, 2'd1, 5'd0, 32'h0, 5'd0, 32'h0, 32'h200, 32'h108, 5'd3, 1'b1, 2'd2);
    step();
    idleIssue();
    checkOutput("lw_ready_exec", {31'b0, bus_fwd.issue_ready_o}, 32'd0);
    step();
    checkOutput("lw_ready_wait", {31'b0, bus_fwd.issue_ready_o}, 32'd0);
    step();
    checkOutput("lw_ready_wait2", {31'b0, bus_fwd.issue_ready_o}, 32'd0);
    checkOutput("lw_no_early_we", {31'b0, bus_fwd.rf_we_o}, 32'd0);
    setMem(1'b1, 32'hDEADBEEF);
    applyStimulus(1'b1, 2'd0, 2'd2, 5'd3, 32'h0, 5'd0, 32'h0, 32'h0, 32'h10C, 5'd4, 1'b1, 2'd0);
    step();
    setMem(1'b0, 32'h0);
    checkOutput("lw_wb_we", {31'b0, bus_fwd.rf_we_o}, 32'd1);
    checkOutput("lw_wb_data", bus_fwd.rf_wdata_o, 32'hDEADBEEF);
    checkOutput("lw_wb_addr", {27'b0, bus_fwd.rf_waddr_o}, 32'd3);
    checkOutput("lw_ready_idle", {31'b0, bus_fwd.issue_ready_o}, 32'd1);
    checkOutput("lw_not_issued", {31'b0, bus_fwd.alu_valid_o}, 32'd0);
    step();
    idleIssue();
    checkOutput("use_wb_fwd", bus_fwd.alu_op_a_o, 32'hDEADBEEF);
    checkOutput("use_nofwd", bus_nofwd.alu_op_a_o, 32'h0);
    checkOutput("lw_we_one_cycle", {31'b0, bus_fwd.rf_we_o}, 32'd0);
    step();
    checkOutput("use_wb_data", bus_fwd.rf_wdata_o, 32'hDEADBEEF);

    // JAL x1 at the top of the address space; rs2 marked invalid
    applyStimulus(1'b1, 2'd1, 2'd0, 5'd0, 32'h0, 5'd7, 32'h55, 32'h0, 32'hFFFFFFFC, 5'd1, 1'b1, 2'd1);
    bus_fwd.rs2_valid_i   = 1'b0;
    bus_nofwd.rs2_valid_i = 1'b0;
    step();
    idleIssue();
    checkOutput("jal_op_a_pc", bus_fwd.alu_op_a_o, 32'hFFFFFFFC);
    checkOutput("jal_invalid_rs2", bus_fwd.alu_op_b_o, 32'h0);
    step();
    checkOutput("jal_link_wrap", bus_fwd.rf_wdata_o, 32'h0);
    checkOutput("jal_link_we", {31'b0, bus_fwd.rf_we_o}, 32'd1);

    // Write to x0 followed by a read of x0
    applyStimulus(1'b1, 2'd3, 2'd1, 5'd0, 32'h0, 5'd0, 32'h0, 32'd7, 32'h200, 5'd0, 1'b1, 2'd0);
    step();
    applyStimulus(1'b1, 2'd0, 2'd2, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h204, 5'd5, 1'b1, 2'd0);
    step();
    idleIssue();
    checkOutput("x0_no_fwd", bus_fwd.alu_op_a_o, 32'h0);
    checkOutput("x0_we_pulse", {31'b0, bus_fwd.rf_we_o}, 32'd1);
    checkOutput("x0_waddr", {27'b0, bus_fwd.rf_waddr_o}, 32'd0);
    checkOutput("x0_wdata", bus_fwd.rf_wdata_o, 32'd7);
    step();

    // Reset in WAIT_MEM while the response and a new instruction arrive
    applyStimulus(1'b1, 2'd0, 2'd1, 5'd0, 32'h0, 5'd0, 32'h0, 32'h40, 32'h300, 5'd6, 1'b1, 2'd2);
    step();
    idleIssue();
    step();
    checkOutput("rst_pre_wait", {31'b0, bus_fwd.issue_ready_o}, 32'd0);
    rst = 1'b1;
    setMem(1'b1, 32'h00001234);
    bus_fwd.issue_valid_i = 1'b1;
    bus_nofwd.issue_valid_i = 1'b1;
    step();
    rst = 1'b0;
    setMem(1'b0, 32'h0);
    idleIssue();
    checkOutput("rst_wait_we", {31'b0, bus_fwd.rf_we_o}, 32'd0);
    checkOutput("rst_wait_ready", {31'b0, bus_fwd.issue_ready_o}, 32'd1);
    checkOutput("rst_wait_valid", {31'b0, bus_fwd.alu_valid_o}, 32'd0);
    checkOutput("rst_wait_op_b", bus_fwd.alu_op_b_o, 32'h0);
    step();
    checkOutput("rst_after_we", {31'b0, bus_fwd.rf_we_o}, 32'd0);
    checkOutput("rst_after_wdata", bus_fwd.rf_wdata_o, 32'h0);

    // Reset wins over a handshake offered from IDLE
    applyStimulus(1'b1, 2'd2, 2'd1, 5'd0, 32'h0, 5'd0, 32'h0, 32'h99, 32'h400, 5'd8, 1'b1, 2'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idleIssue();
    checkOutput("rst_hs_valid", {31'b0, bus_fwd.alu_valid_o}, 32'd0);
    checkOutput("rst_hs_op_a", bus_fwd.alu_op_a_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/exec_operand_stage.md
EXEC_OPERAND_STAGE -- requirements
Module: exec_operand_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand/result width.
REQ-002 SHALL have parameter RF_ADDR_WIDTH, default 5, meaning register-index width.
REQ-003 SHALL have parameter FWD_EN, default 1, meaning 1 = operand forwarding enabled, 0 = disabled.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk_i  in  1  rising-edge clock; rst_i  in  1  reset.
REQ-005 SHALL have ports, each listed as name  direction  width  meaning:
- issue_valid_i  in  1  decoded instruction offered
- issue_ready_o  out  1  stage accepts instruction
- op_a_sel_i  in  2  0 = REG, 1 = PC, 2 = IMM, 3 = zero
- op_b_sel_i  in  2  0 = REG, 1 = IMM, 2/3 = zero
- rs1_valid_i / rs2_valid_i / imm_valid_i  in  1 each  source valid
- rs1_addr_i / rs2_addr_i  in  RF_ADDR_WIDTH  source indices
- rs1_data_i / rs2_data_i  in  DATA_WIDTH  register-file read data
- imm_i, pc_i  in  DATA_WIDTH  immediate, instruction PC
- rd_addr_i  in  RF_ADDR_WIDTH; rd_we_i  in  1  destination and write enable
- wb_sel_i  in  2  0 = ALU, 1 = PC+4, 2 = LSU, 3 = ALU
- alu_valid_o  out  1; alu_op_a_o / alu_op_b_o  out  DATA_WIDTH  registered operands
- alu_result_i  in  DATA_WIDTH  combinational ALU result for the current alu_op_*
- mem_rvalid_i  in  1; mem_rdata_i  in  DATA_WIDTH  LSU response
- rf_we_o  out  1; rf_waddr_o  out  RF_ADDR_WIDTH; rf_wdata_o  out  DATA_WIDTH  registered writeback

Function
REQ-006 SHALL have FSM states IDLE (EX empty), EXEC (alu_valid_o = 1), WAIT_MEM (load/store outstanding).
REQ-007 SHALL define a handshake as the cycle where issue_valid_i && issue_ready_o; issue_ready_o = (IDLE) or (EXEC and latched wb_sel != LSU); it is 0 in WAIT_MEM.
REQ-008 SHALL, on a handshake, register the operands, rd_addr_i, rd_we_i, wb_sel_i and pc_i, with 1-cycle latency: alu_valid_o is 1 in the next cycle.
REQ-009 SHALL select operands per op_*_sel_i; an invalid source (rs*_valid_i = 0 or imm_valid_i = 0) yields 0.
REQ-010 SHALL compute PC+4 internally as latched pc + 4, modulo 2^DATA_WIDTH (0xFFFFFFFC -> 0x0).
REQ-011 SHALL forward when FWD_EN = 1, for a REG source with a nonzero index, using this priority:
- (a) EX hazard (alu_valid_o, latched rd_we, latched rd == rs): alu_result_i if latched wb_sel is ALU, PC+4 if it is PC+4.
- (b) WB hazard (rf_we_o, rf_waddr_o == rs): rf_wdata_o.
- (c) otherwise rs*_data_i.
- Index 0 is never forwarded.
REQ-012 SHALL, from EXEC with wb_sel ALU/PC+4: register rf_wdata_o, rf_waddr_o, and rf_we_o = latched rd_we at the next edge; go to EXEC on a handshake, else IDLE.
REQ-013 SHALL, from EXEC with wb_sel LSU: go to WAIT_MEM, ignoring mem_rvalid_i in the EXEC cycle.
REQ-014 SHALL, in WAIT_MEM on mem_rvalid_i: register rf_wdata_o = mem_rdata_i and rf_we_o = latched rd_we (a store has 0), then go to IDLE; without mem_rvalid_i it holds indefinitely.
REQ-015 SHALL hold rf_we_o high for exactly one cycle per write; rf_waddr_o/rf_wdata_o hold their value when rf_we_o = 0.
REQ-016 SHALL, with rd_addr = 0, still pulse rf_we_o; register-file x0 suppression is downstream.

Reset
REQ-017 SHALL, on rst_i high at an edge: set state IDLE; set alu_valid_o, rf_we_o, alu_op_a_o, alu_op_b_o, rf_waddr_o, rf_wdata_o to 0; issue_ready_o = 1 in the following cycle.
REQ-018 SHALL let reset override every transition, including mid-WAIT_MEM (the pending write is dropped) and a simultaneous handshake.

Verification
REQ-019 SHALL cover ADDI chain: x1 = 5 written via WB, then ADD x2 = x1 + x1 issued back-to-back -> alu_op_a_o = alu_op_b_o = 5 via EX forward; rf_wdata_o = 10 next cycle.
REQ-020 SHALL cover load-use: LW x3 issued, mem_rvalid_i 3 cycles later with 0xDEADBEEF -> issue_ready_o low in EXEC and WAIT_MEM; rf_we_o = 1, rf_wdata_o = 0xDEADBEEF; a dependent op gets 0xDEADBEEF via WB forward.
REQ-021 SHALL cover JAL with pc_i = 0xFFFFFFFC, wb_sel = PC+4 -> rf_wdata_o = 0x00000000.
REQ-022 SHALL cover forwarding to x0: rd = 0, a following op reads rs1 = 0 with rs1_data_i = 0 -> operand 0, no forward.
REQ-023 SHALL cover reset asserted in WAIT_MEM with a concurrent mem_rvalid_i -> rf_we_o stays 0; IDLE; issue_ready_o = 1.
REQ-024 SHALL cover FWD_EN = 0 with the back-to-back dependency -> operand equals rs1_data_i.
